uart_num_receiver: RTL and testbench
====================================

# uart_num_receiver

Receive-side UART stage for the two-board number link. Sits on the second FPGA directly downstream of a `Transmitter` serial line. Recovers 8-bit frames (1 start, 8 data LSB-first, 1 stop, no parity) and converts each accepted value 0..99 to tens/units BCD for the existing seven-segment path. One instance is used per serial line, so two instances cover both numbers.

## Interface
Parameters:
- CLKS_PER_BIT, 5208, `clk` cycles per bit; must match the transmitter (50 MHz / 9600 baud). Legal range is 4 or more.

Ports:
- clk  in  1  system clock; the only clock in the block
- rst  in  1  reset; synchronous, active-high
- serial_in  in  1  asynchronous serial line; idles high
- rx_data  out  8  last accepted byte, held until the next accepted frame
- rx_valid  out  1  one-cycle pulse when a good frame updates rx_data, tens and units
- frame_err  out  1  one-cycle pulse when the stop bit samples 0
- rx_active  out  1  high in the START, DATA and STOP states
- tens  out  4  BCD tens digit of rx_data
- units  out  4  BCD units digit of rx_data
- range_err  out  1  high while the held rx_data is greater than 99

## Operation
- Input conditioning: serial_in passes through a 2-flop synchronizer giving `rx_s`. All decisions use `rx_s`. The synchronizer flops reset to 1.
- Counters:
  - `clk_cnt` is wide enough to hold CLKS_PER_BIT-1.
  - `bit_idx` is 3 bits.
  - H = (CLKS_PER_BIT-1)/2, using integer division.
- State IDLE:
  - `clk_cnt` = 0 and `bit_idx` = 0.
  - If `rx_s` = 0, go to START.
- State START:
  - Increment `clk_cnt`.
  - When `clk_cnt` = H, sample `rx_s`.
  - If the sample is 0, clear `clk_cnt` and go to DATA.
  - If the sample is 1, treat it as a glitch and go to IDLE with no pulse.
- State DATA:
  - When `clk_cnt` = CLKS_PER_BIT-1, sample `rx_s` into shift bit `bit_idx` and clear `clk_cnt`.
  - After `bit_idx` = 7 is sampled, go to STOP.
  - Otherwise increment `bit_idx`.
- State STOP:
  - When `clk_cnt` = CLKS_PER_BIT-1, sample `rx_s` and go to IDLE.
  - If the sample is 1, load rx_data, tens, units and range_err from the shift register, and pulse rx_valid in the same cycle as the load.
  - If the sample is 0, pulse frame_err. rx_data, tens, units and range_err keep their previous values.
- BCD conversion:
  - Source is the 8-bit shift register value v.
  - If v ≤ 99: tens = v/10, units = v%10, range_err = 0.
  - If v > 99: tens = 0, units = 0, range_err = 1, and rx_data still loads v.
  - The conversion may be combinational ahead of the load register; no extra latency is permitted.
- Reset: at any state or count, rst returns the block to IDLE on the next clk edge.
  - No rx_valid or frame_err pulse is issued for an aborted frame.
  - All outputs reset to 0: rx_data, tens, units, range_err, rx_valid, frame_err, rx_active.

## Timing
- Let cycle t be the first cycle `rx_s` = 0 while in IDLE. That is 2 cycles after the falling edge reaches the synchronizer input.
- Cycle t+1: state = START, `clk_cnt` = 0, rx_active goes high.
- Start bit is verified at cycle t+1+H.
- Data bit i is sampled at cycle t+1+H+(i+1)·CLKS_PER_BIT, for i = 0..7.
- Stop bit is sampled at cycle t+1+H+9·CLKS_PER_BIT.
- In cycle t+2+H+9·CLKS_PER_BIT:
  - Exactly one of rx_valid or frame_err is high, for exactly 1 cycle.
  - rx_active is 0.
  - New rx_data, tens, units and range_err are visible in this cycle.
- Back-to-back frames: IDLE accepts a start bit in the same cycle it is entered. A start bit immediately following a stop bit is not lost.
- rx_valid and frame_err are never high together.
- Both are registered outputs with no combinational path from serial_in.

## Test plan
Bench uses CLKS_PER_BIT = 16 (H = 7) and drives serial_in with an ideal transmitter model.
1. Reset, then hold the line high for 500 cycles -> all outputs 0, no pulses, rx_active stays 0.
2. Send 0x2A (42) -> a single rx_valid pulse exactly 2+2+7+144 cycles after the start edge at the pin; rx_data = 42, tens = 4, units = 2, range_err = 0.
3. Send 200 (0xC8) -> rx_valid pulse, rx_data = 200, tens = 0, units = 0, range_err = 1. Then send 99 -> tens = 9, units = 9, range_err = 0.
4. Send 0x2A, then a frame 0x17 with the stop bit forced to 0 -> frame_err pulse for 1 cycle, no rx_valid, and rx_data/tens/units remain 42/4/2.
5. Drive a 4-cycle low glitch on the idle line -> rx_active rises then falls by START+H, with no rx_valid, no frame_err and outputs unchanged. Then send two frames, 5 and 73, back-to-back with no idle gap -> two rx_valid pulses, with final digits 7/3.
6. Assert rst for 1 cycle during data bit 3 of a frame -> the next cycle is IDLE, all outputs are 0 and no pulse occurs. A subsequent frame of 61 is received correctly (tens = 6, units = 1).

Source files
------------

// File: rtl/uart_num_if.sv
// Receiver-side bundle for one serial number link: the line in, the
// recovered byte and its BCD digits out.
interface uart_num_if;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_active;
  logic [3:0] tens;
  logic [3:0] units;
  logic       range_err;

  // master: the side driving the line and consuming the results
  modport master (
    output serial_in,
    input  rx_data, rx_valid, frame_err, rx_active, tens, units, range_err
  );

  // slave: the receiver itself
  modport slave (
    input  serial_in,
    output rx_data, rx_valid, frame_err, rx_active, tens, units, range_err
  );
endinterface

// File: rtl/uart_num_receiver.sv
// 8N1 UART receiver with mid-bit sampling and 0..99 to tens/units BCD.
// Values above 99 still load rx_data but flag range_err with zero digits.
module uart_num_receiver #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic      clk,
  input  logic      rst,
  uart_num_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(H);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             sync1, rx_s;

  logic [7:0] data_q;
  logic [3:0] tens_q, units_q;
  logic       range_q, valid_q, ferr_q;

  logic [3:0] tens_n, units_n;
  logic       range_n;
  logic [7:0] rem;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.serial_in;
      rx_s  <= sync1;
    end
  end

  // Binary to BCD on the assembled byte, ahead of the output register
  always_comb begin
    tens_n  = '0;
    units_n = '0;
    range_n = 1'b0;
    rem     = shift;
    if (shift > 8'd99) begin
      range_n = 1'b1;
    end else begin
      for (int k = 1; k < 10; k++) begin
        if (shift >= 8'(k * 10)) begin
          tens_n = 4'(k);
          rem    = shift - 8'(k * 10);
        end
      end
      units_n = 4'(rem);
    end
  end

  // Frame FSM: start verified at half-bit, then one sample per bit period
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      range_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (clk_cnt == CNT_MID) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            if (rx_s) begin
              data_q  <= shift;
              tens_q  <= tens_n;
              units_q <= units_n;
              range_q <= range_n;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.tens      = tens_q;
  assign bus.units     = units_q;
  assign bus.range_err = range_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_active = (state != IDLE);
endmodule

// File: tb/tb_uart_num_receiver.sv
// Bench for uart_num_receiver at 16 clocks/bit: directed table, corner
// sequences (glitch, back-to-back, mid-frame reset) and random frames.
module tb_uart_num_receiver;
  localparam int CPB = 16;
  localparam int LAT = 2 + 2 + (CPB - 1) / 2 + 9 * CPB;  // pin edge -> pulse

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   act_cnt = 0;
  int   last_start = 0;

  uart_num_if bus();

  uart_num_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 1 = rx_valid, 2 = frame_err, 3 = both
    int cyc;
    int data, tens, units, rng, act;
  } ev_t;
  ev_t evq[$];

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.rx_active) act_cnt <= act_cnt + 1;
    if (!rst && (bus.rx_valid || bus.frame_err)) begin
      ev_t e;
      e.kind  = (bus.rx_valid ? 1 : 0) + (bus.frame_err ? 2 : 0);
      e.cyc   = cyc;
      e.data  = int'(bus.rx_data);
      e.tens  = int'(bus.tens);
      e.units = int'(bus.units);
      e.rng   = int'(bus.range_err);
      e.act   = int'(bus.rx_active);
      evq.push_back(e);
    end
  end

  typedef struct {
    logic [7:0] v;
    bit         stop;
    int         kind, data, tens, units, rng;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic idle(input int n);
    bus.serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Ideal transmitter; a bad stop bit is followed by idle time so the
  // receiver can drop the false start the low stop level produces
  task automatic send_frame(input logic [7:0] v, input bit stop);
    last_start = cyc;
    bus.serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = v[i];
      repeat (CPB) @(negedge clk);
    end
    bus.serial_in = stop;
    repeat (CPB) @(negedge clk);
    bus.serial_in = 1'b1;
    if (!stop) repeat (24) @(negedge clk);
  endtask

  task automatic expect_ev(input string nm, input int start, input int kind,
                           input int data, input int tens, input int units,
                           input int rng);
    ev_t e;
    chk({nm, "_nev"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({nm, "_kind"},  e.kind, kind);
      chk({nm, "_lat"},   e.cyc - start, LAT);
      chk({nm, "_data"},  e.data, data);
      chk({nm, "_tens"},  e.tens, tens);
      chk({nm, "_units"}, e.units, units);
      chk({nm, "_rng"},   e.rng, rng);
      chk({nm, "_act"},   e.act, 0);
    end
    evq.delete();
  endtask

  task automatic chk_outs(input string nm, input int data, input int tens,
                          input int units, input int rng);
    chk({nm, "_data"},  int'(bus.rx_data), data);
    chk({nm, "_tens"},  int'(bus.tens), tens);
    chk({nm, "_units"}, int'(bus.units), units);
    chk({nm, "_rng"},   int'(bus.range_err), rng);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, s0, s1;
    int m_data, m_tens, m_units, m_rng;

    tbl[0] = '{8'd42,  1'b1, 1, 42,  4, 2, 0};
    tbl[1] = '{8'd200, 1'b1, 1, 200, 0, 0, 1};
    tbl[2] = '{8'd99,  1'b1, 1, 99,  9, 9, 0};
    tbl[3] = '{8'd42,  1'b1, 1, 42,  4, 2, 0};
    tbl[4] = '{8'h17,  1'b0, 2, 42,  4, 2, 0};

    // Reset, then a long quiet line
    bus.serial_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_outs("reset", 0, 0, 0, 0);
    chk("reset_valid", int'(bus.rx_valid), 0);
    chk("reset_ferr", int'(bus.frame_err), 0);
    chk("reset_act", int'(bus.rx_active), 0);
    a0 = act_cnt;
    idle(500);
    chk("quiet_act", act_cnt - a0, 0);
    chk("quiet_nev", evq.size(), 0);
    chk_outs("quiet", 0, 0, 0, 0);

    // Directed frames
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].v, tbl[i].stop);
      idle(4);
      expect_ev($sformatf("tbl%0d", i), last_start, tbl[i].kind,
                tbl[i].data, tbl[i].tens, tbl[i].units, tbl[i].rng);
      chk_outs($sformatf("tbl%0d_hold", i), tbl[i].data, tbl[i].tens,
               tbl[i].units, tbl[i].rng);
    end

    // 4-cycle low glitch: START lasts H+1 cycles then falls back to IDLE
    a0 = act_cnt;
    bus.serial_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    chk("glitch_act", act_cnt - a0, (CPB - 1) / 2 + 1);
    chk("glitch_nev", evq.size(), 0);
    chk_outs("glitch", 42, 4, 2, 0);

    // Back-to-back frames with no idle gap
    send_frame(8'd5, 1'b1);
    s0 = last_start;
    send_frame(8'd73, 1'b1);
    s1 = last_start;
    idle(4);
    chk("b2b_nev", evq.size(), 2);
    if (evq.size() == 2) begin
      chk("b2b0_lat", evq[0].cyc - s0, LAT);
      chk("b2b0_units", evq[0].units, 5);
      chk("b2b1_lat", evq[1].cyc - s1, LAT);
      chk("b2b1_kind", evq[1].kind, 1);
    end
    evq.delete();
    chk_outs("b2b", 73, 7, 3, 0);

    // One-cycle reset while the receiver is assembling data bit 3
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (4 * CPB + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_act", int'(bus.rx_active), 0);
        chk("midrst_valid", int'(bus.rx_valid), 0);
        chk("midrst_ferr", int'(bus.frame_err), 0);
        chk_outs("midrst", 0, 0, 0, 0);
      end
    join
    idle(40);
    chk("midrst_nev", evq.size(), 0);
    send_frame(8'd61, 1'b1);
    idle(4);
    expect_ev("after_rst", last_start, 1, 61, 6, 1, 0);

    // Random frames against a value-level model of the held outputs
    m_data = 61; m_tens = 6; m_units = 1; m_rng = 0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] v;
      bit stop;
      int kind;
      v    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(v, stop);
      if (stop) begin
        kind   = 1;
        m_data = int'(v);
        if (v <= 8'd99) begin
          m_tens = int'(v) / 10; m_units = int'(v) % 10; m_rng = 0;
        end else begin
          m_tens = 0; m_units = 0; m_rng = 1;
        end
      end else begin
        kind = 2;
      end
      expect_ev($sformatf("rnd%0d", n), last_start, kind,
                m_data, m_tens, m_units, m_rng);
      idle(int'($urandom_range(0, 12)));
    end
    idle(10);
    chk("end_nev", evq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
